bypass_select_generator: RTL and testbench
==========================================

Name: bypass_select_generator

Overview:
- Produces the per-operand bypass select (stage, lane, valid) that the bypass network consumes.
- Tracks destination physical-register tags of in-flight int and mem producers in a tag pipeline that shadows the bypass data stage registers.
- Compares each consumer source tag against that pipeline in the register-read cycle.
- Registers the result so the select is valid in the cycle the bypassed data sits in the network's EX/WB or MA/WB stage registers.

Parameters:
- INT_LANES, 2, number of int issue lanes producing results
- MEM_LANES, 2, number of load lanes producing results
- NUM_SRC, 4, number of consumer source operands served (lanes x operands, flattened)
- PREG_W, 7, physical register tag width
- LANE_W, 1, width of lane index field (>= clog2(max(INT_LANES,MEM_LANES)))

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- stall  in  1  backend stall; hold all state
- clear  in  1  backend flush; synchronous invalidate of all state
- int_dst_valid  in  INT_LANES  int producer entering EX next cycle
- int_dst_tag  in  INT_LANES*PREG_W  its destination tag
- mem_dst_valid  in  MEM_LANES  load producer entering MA next cycle
- mem_dst_tag  in  MEM_LANES*PREG_W  its destination tag
- src_valid  in  NUM_SRC  consumer operand in register-read this cycle
- src_tag  in  NUM_SRC*PREG_W  consumer source tag
- sel_valid  out  NUM_SRC  bypass required (registered)
- sel_stg  out  NUM_SRC*2  0=INT_EX 1=INT_WB 2=MEM_MA 3=MEM_WB (registered)
- sel_lane  out  NUM_SRC*LANE_W  producer lane within stage (registered)
- multi_hit  out  1  more than one producer matched some operand last cycle (registered)

Behaviour:
- Tag pipeline per lane: EX/MA register captures dst valid+tag; WB register captures EX/MA register.
- Pipeline updates on every non-stalled edge, identical to the network's data stages.
- Reset (rst=0, async): all tag valids 0, sel_valid=0, sel_stg=0, sel_lane=0, multi_hit=0.
- clear (sync, priority over stall): all tag valids and sel_valid cleared next edge; tags may retain value.
- stall=1 and clear=0: all registers, including outputs, hold.
- Comparison happens in cycle t, against the state the data will be in at t+1:
  - incoming dst inputs match gives stage INT_EX / MEM_MA;
  - current EX/MA register match gives stage INT_WB / MEM_WB;
  - current WB register content is retired to the register file and is not a bypass source.
- Select appears at t+1 (latency 1).
- src_valid=0: sel_valid=0 next cycle, stg/lane 0.
- Tag 0 is an ordinary tag (no zero-register suppression; the rename stage never maps x0 to a bypassed producer).
- Priority on multiple matches: younger stage first (EX/MA before WB); within a stage int before mem; lower lane index first.
- multi_hit=1 if any operand had two or more matches; it is a diagnostic and does not change the select.
- No match: sel_valid=0, stg=0, lane=0.
- Same-cycle dst input and consumer request on the same tag gives stage EX/MA (back-to-back forwarding).

Optional Feature:
- Macro: BYPASS_SEL_HIT_COUNT_EN.
- When defined, two extra outputs:
  - hit_count (32 bits): increments by the number of operands with sel_valid going to 1 on each non-stalled edge;
  - req_count (32 bits): counts accepted src_valid operands.
- Both counters saturate at 0xFFFFFFFF, reset to 0 asynchronously, hold on stall, and are not cleared by clear.
- When undefined: ports and counters are absent, with no other change.

Test Plan:
- Reset: drive rst=0 mid-run with valid tags in flight -> all outputs 0 immediately; after release, src_tag=5 with no producers -> sel_valid=0.
- Back-to-back: int lane1 dst tag 0x12 and src0 tag 0x12 in cycle t -> at t+1 sel_valid[0]=1, stg=0, lane=1; repeat src at t+1 -> at t+2 stg=1, lane=1; src at t+2 -> sel_valid=0.
- Mem path: mem lane0 dst tag 0x30 at t, src3 tag 0x30 at t+1 -> at t+2 stg=3, lane=0.
- Priority/multi-hit: int lane0 tag 0x07 at t, mem lane1 tag 0x07 at t+1, src1 tag 0x07 at t+1 -> at t+2 stg=2, lane=1, multi_hit=1.
- Stall: producer tag 0x09 at t, stall=1 for 3 cycles, then src tag 0x09 on the first unstalled cycle -> stg=1, and outputs frozen during the stall.
- Clear: producer tag 0x0A in EX, clear=1 with stall=1 -> next cycle, src tag 0x0A gives sel_valid=0; with BYPASS_SEL_HIT_COUNT_EN, counters keep their prior values.

Source files
------------

// File: rtl/bypass_select_generator.sv
// rtl/bypass_select_generator.sv - per-operand bypass select from an in-flight producer tag pipeline
// Optional macro BYPASS_SEL_HIT_COUNT_EN adds saturating hit_count/req_count outputs.
module bypass_select_generator #(
  parameter int INT_LANES = 2,
  parameter int MEM_LANES = 2,
  parameter int NUM_SRC   = 4,
  parameter int PREG_W    = 7,
  parameter int LANE_W    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          clear,
  input  logic [INT_LANES-1:0]          int_dst_valid,
  input  logic [INT_LANES*PREG_W-1:0]   int_dst_tag,
  input  logic [MEM_LANES-1:0]          mem_dst_valid,
  input  logic [MEM_LANES*PREG_W-1:0]   mem_dst_tag,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*PREG_W-1:0]     src_tag,
  output logic [NUM_SRC-1:0]            sel_valid,
  output logic [NUM_SRC*2-1:0]          sel_stg,
  output logic [NUM_SRC*LANE_W-1:0]     sel_lane,
  output logic                          multi_hit
`ifdef BYPASS_SEL_HIT_COUNT_EN
  ,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   req_count
`endif
);

  localparam int NCAND = 2 * (INT_LANES + MEM_LANES);

  localparam logic [1:0] STG_INT_EX = 2'd0;
  localparam logic [1:0] STG_INT_WB = 2'd1;
  localparam logic [1:0] STG_MEM_MA = 2'd2;
  localparam logic [1:0] STG_MEM_WB = 2'd3;

  // Only the EX/MA tag stage is kept: WB-stage content is retired and never a bypass source.
  logic [INT_LANES-1:0]        int_ex_v_q;
  logic [INT_LANES*PREG_W-1:0] int_ex_tag_q;
  logic [MEM_LANES-1:0]        mem_ma_v_q;
  logic [MEM_LANES*PREG_W-1:0] mem_ma_tag_q;

  logic [NUM_SRC-1:0]          sel_valid_q, sel_valid_d;
  logic [NUM_SRC*2-1:0]        sel_stg_q, sel_stg_d;
  logic [NUM_SRC*LANE_W-1:0]   sel_lane_q, sel_lane_d;
  logic                        multi_hit_q, multi_hit_d;

  logic              cand_v    [NCAND];
  logic [PREG_W-1:0] cand_tag  [NCAND];
  logic [1:0]        cand_stg  [NCAND];
  logic [LANE_W-1:0] cand_lane [NCAND];

  // Candidates listed in priority order: incoming int, incoming mem, EX int, MA mem.
  always_comb begin
    for (int i = 0; i < INT_LANES; i++) begin
      cand_v[i]                           = int_dst_valid[i];
      cand_tag[i]                         = int_dst_tag[i*PREG_W +: PREG_W];
      cand_stg[i]                         = STG_INT_EX;
      cand_lane[i]                        = LANE_W'(i);
      cand_v[INT_LANES+MEM_LANES+i]       = int_ex_v_q[i];
      cand_tag[INT_LANES+MEM_LANES+i]     = int_ex_tag_q[i*PREG_W +: PREG_W];
      cand_stg[INT_LANES+MEM_LANES+i]     = STG_INT_WB;
      cand_lane[INT_LANES+MEM_LANES+i]    = LANE_W'(i);
    end
    for (int m = 0; m < MEM_LANES; m++) begin
      cand_v[INT_LANES+m]                 = mem_dst_valid[m];
      cand_tag[INT_LANES+m]               = mem_dst_tag[m*PREG_W +: PREG_W];
      cand_stg[INT_LANES+m]               = STG_MEM_MA;
      cand_lane[INT_LANES+m]              = LANE_W'(m);
      cand_v[2*INT_LANES+MEM_LANES+m]     = mem_ma_v_q[m];
      cand_tag[2*INT_LANES+MEM_LANES+m]   = mem_ma_tag_q[m*PREG_W +: PREG_W];
      cand_stg[2*INT_LANES+MEM_LANES+m]   = STG_MEM_WB;
      cand_lane[2*INT_LANES+MEM_LANES+m]  = LANE_W'(m);
    end
  end

  always_comb begin
    sel_valid_d = '0;
    sel_stg_d   = '0;
    sel_lane_d  = '0;
    multi_hit_d = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int c = 0; c < NCAND; c++) begin
        if (src_valid[s] && cand_v[c] && (cand_tag[c] == src_tag[s*PREG_W +: PREG_W])) begin
          if (sel_valid_d[s]) begin
            multi_hit_d = 1'b1;
          end else begin
            sel_valid_d[s]                  = 1'b1;
            sel_stg_d[s*2 +: 2]             = cand_stg[c];
            sel_lane_d[s*LANE_W +: LANE_W]  = cand_lane[c];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_ex_v_q   <= '0;
      int_ex_tag_q <= '0;
      mem_ma_v_q   <= '0;
      mem_ma_tag_q <= '0;
      sel_valid_q  <= '0;
      sel_stg_q    <= '0;
      sel_lane_q   <= '0;
      multi_hit_q  <= 1'b0;
    end else if (clear) begin
      int_ex_v_q   <= '0;
      mem_ma_v_q   <= '0;
      sel_valid_q  <= '0;
      sel_stg_q    <= '0;
      sel_lane_q   <= '0;
      multi_hit_q  <= 1'b0;
    end else if (!stall) begin
      int_ex_v_q   <= int_dst_valid;
      int_ex_tag_q <= int_dst_tag;
      mem_ma_v_q   <= mem_dst_valid;
      mem_ma_tag_q <= mem_dst_tag;
      sel_valid_q  <= sel_valid_d;
      sel_stg_q    <= sel_stg_d;
      sel_lane_q   <= sel_lane_d;
      multi_hit_q  <= multi_hit_d;
    end
  end

  assign sel_valid = sel_valid_q;
  assign sel_stg   = sel_stg_q;
  assign sel_lane  = sel_lane_q;
  assign multi_hit = multi_hit_q;

`ifdef BYPASS_SEL_HIT_COUNT_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] req_count_q, req_count_d;
  logic [32:0] hit_sum, req_sum;
  logic [31:0] hit_inc, req_inc;

  always_comb begin
    hit_inc = '0;
    req_inc = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      hit_inc = hit_inc + 32'(sel_valid_d[s]);
      req_inc = req_inc + 32'(src_valid[s]);
    end
    hit_sum     = {1'b0, hit_count_q} + {1'b0, hit_inc};
    req_sum     = {1'b0, req_count_q} + {1'b0, req_inc};
    hit_count_d = hit_sum[32] ? 32'hFFFF_FFFF : hit_sum[31:0];
    req_count_d = req_sum[32] ? 32'hFFFF_FFFF : req_sum[31:0];
  end

  // A flush edge discards the cycle's requests, so nothing is counted on it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_q <= '0;
      req_count_q <= '0;
    end else if (!stall && !clear) begin
      hit_count_q <= hit_count_d;
      req_count_q <= req_count_d;
    end
  end

  assign hit_count = hit_count_q;
  assign req_count = req_count_q;
`endif

endmodule

// File: tb/tb_bypass_select_generator.sv
// tb/tb_bypass_select_generator.sv - table-driven scoreboard bench for bypass_select_generator
module tb_bypass_select_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, clear;
  logic [1:0]  int_dst_valid, mem_dst_valid;
  logic [13:0] int_dst_tag, mem_dst_tag;
  logic [3:0]  src_valid;
  logic [27:0] src_tag;
  logic [3:0]  sel_valid;
  logic [7:0]  sel_stg;
  logic [3:0]  sel_lane;
  logic        multi_hit;
`ifdef BYPASS_SEL_HIT_COUNT_EN
  logic [31:0] hit_count, req_count;
  logic [31:0] mdl_hit = 0, mdl_req = 0;
`endif

  always #5 clk = ~clk;

  bypass_select_generator dut (
    .clk(clk), .rst(rst), .stall(stall), .clear(clear),
    .int_dst_valid(int_dst_valid), .int_dst_tag(int_dst_tag),
    .mem_dst_valid(mem_dst_valid), .mem_dst_tag(mem_dst_tag),
    .src_valid(src_valid), .src_tag(src_tag),
    .sel_valid(sel_valid), .sel_stg(sel_stg), .sel_lane(sel_lane),
    .multi_hit(multi_hit)
`ifdef BYPASS_SEL_HIT_COUNT_EN
    , .hit_count(hit_count), .req_count(req_count)
`endif
  );

  typedef struct packed {
    logic [3:0] v;
    logic [7:0] stg;
    logic [3:0] lane;
    logic       m;
  } exp_t;

  typedef struct packed {
    logic [1:0]  int_v;
    logic [13:0] int_tag;
    logic [1:0]  mem_v;
    logic [13:0] mem_tag;
    logic [3:0]  src_v;
    logic [27:0] src_tag;
    logic        stall;
    logic        clear;
    exp_t        e;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t last_exp = '0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // pk: 0 none, 1 int lane pl, 2 mem lane pl, 3 both int lanes; sidx<0 means no consumer.
  function automatic vec_t mk(int pk, int pl, int ptag, int sidx, int stag, bit st, bit cl,
                              bit ev, int estg, int elane, bit em);
    vec_t r = '0;
    case (pk)
      1: begin r.int_v[pl] = 1'b1; r.int_tag[pl*7 +: 7] = 7'(ptag); end
      2: begin r.mem_v[pl] = 1'b1; r.mem_tag[pl*7 +: 7] = 7'(ptag); end
      3: begin r.int_v = 2'b11; r.int_tag = {7'(ptag), 7'(ptag)}; end
      default: ;
    endcase
    if (sidx >= 0) begin
      r.src_v[sidx] = 1'b1;
      r.src_tag[sidx*7 +: 7] = 7'(stag);
      if (ev) begin
        r.e.v[sidx] = 1'b1;
        r.e.stg[sidx*2 +: 2] = 2'(estg);
        r.e.lane[sidx] = 1'(elane);
      end
    end
    r.e.m = em;
    r.stall = st;
    r.clear = cl;
    return r;
  endfunction

  task automatic run_row(input vec_t r, input string nm);
    exp_t e, got;
    int_dst_valid = r.int_v;  int_dst_tag = r.int_tag;
    mem_dst_valid = r.mem_v;  mem_dst_tag = r.mem_tag;
    src_valid     = r.src_v;  src_tag     = r.src_tag;
    stall         = r.stall;  clear       = r.clear;
    if (r.clear)      e = '0;
    else if (r.stall) e = last_exp;
    else              e = r.e;
    sb_q.push_back(e);
`ifdef BYPASS_SEL_HIT_COUNT_EN
    if (!r.stall && !r.clear) begin
      mdl_req += $countones(r.src_v);
      mdl_hit += $countones(e.v);
    end
`endif
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({nm, " sel_valid"}, 32'(sel_valid), 32'(got.v));
    chk({nm, " sel_stg"},   32'(sel_stg),   32'(got.stg));
    chk({nm, " sel_lane"},  32'(sel_lane),  32'(got.lane));
    chk({nm, " multi_hit"}, 32'(multi_hit), 32'(got.m));
    last_exp = got;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " sel_valid"}, 32'(sel_valid), 0);
    chk({nm, " sel_stg"},   32'(sel_stg),   0);
    chk({nm, " sel_lane"},  32'(sel_lane),  0);
    chk({nm, " multi_hit"}, 32'(multi_hit), 0);
`ifdef BYPASS_SEL_HIT_COUNT_EN
    chk({nm, " hit_count"}, hit_count, 0);
    chk({nm, " req_count"}, req_count, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; stall = 1'b0; clear = 1'b0;
    int_dst_valid = '0; int_dst_tag = '0; mem_dst_valid = '0; mem_dst_tag = '0;
    src_valid = '0; src_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;

    tbl.push_back(mk(0, 0, 0,    0, 'h05, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 'h12, 0, 'h12, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,    0, 'h12, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,    0, 'h12, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 'h30, -1, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,    3, 'h30, 0, 0, 1, 3, 0, 0));
    tbl.push_back(mk(1, 0, 'h07, -1, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 1, 'h07, 1, 'h07, 0, 0, 1, 2, 1, 1));
    tbl.push_back(mk(0, 0, 0,    1, 'h07, 0, 0, 1, 3, 1, 0));
    tbl.push_back(mk(1, 0, 'h09, 2, 'h09, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(2, 1, 'h55, 2, 'h09, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,    2, 'h09, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,    2, 'h55, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 'h0A, -1, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 'h0A, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 'h0A, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3, 0, 'h20, 1, 'h20, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    1, 'h20, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(2, 1, 0,    0, 0,    0, 0, 1, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0,    -1, 0,   0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++)
      run_row(tbl[i], $sformatf("row%0d", i));

    // Asynchronous reset with a producer in flight and another arriving.
    run_row(mk(1, 0, 'h11, 0, 'h11, 0, 0, 1, 0, 0, 0), "pre_rst");
    int_dst_valid = 2'b10; int_dst_tag = {7'h11, 7'h00};
    #3;
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
`ifdef BYPASS_SEL_HIT_COUNT_EN
    mdl_hit = 0; mdl_req = 0;
`endif
    last_exp = '0;
    @(posedge clk);
    #1;
    chk_zero("rst_held");
    rst = 1'b1;
    run_row(mk(0, 0, 0, 0, 'h05, 0, 0, 0, 0, 0, 0), "post_rst_tag5");
    run_row(mk(0, 0, 0, 0, 'h11, 0, 0, 0, 0, 0, 0), "post_rst_tag11");
    run_row(mk(2, 0, 'h44, 3, 'h44, 0, 0, 1, 2, 0, 0), "post_rst_mem");

`ifdef BYPASS_SEL_HIT_COUNT_EN
    chk("hit_count", hit_count, mdl_hit);
    chk("req_count", req_count, mdl_req);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
